// File: rtl/pair_pulse_tx.sv
// pair_pulse_tx: serial stimulus source for the idle/s0/s1 pair-detect receiver.
// Emits a lead-in of zeros followed by count pairs of '1' bits. Each '1' is separated
// by gap zero cycles, so the receiver fires dout exactly count times. mark flags
// the second '1' of each pair, which is the bit on which the receiver asserts dout.
module pair_pulse_tx #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 4,
  parameter int unsigned LEAD  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             ready,
  output logic             ser,
  output logic             mark,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent
);

  // One down-counter is shared by the lead-in and both gap phases. It holds LEAD-1
  // or gap-1, so it needs enough bits for whichever of the two is larger.
  localparam int unsigned LeadW = (LEAD > 1) ? $clog2(LEAD) : 1;
  localparam int unsigned TimW  = (GAP_W > LeadW) ? GAP_W : LeadW;
  localparam logic [TimW-1:0] LeadLoad = TimW'(LEAD - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StArm,
    StGapA,
    StFire,
    StGapB,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [TimW-1:0]  tim_q, tim_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] sent_d;
  logic [TimW-1:0]  gap_load;
  logic             accept;
  logic             tim_zero;
  logic             last_pair;

  assign accept    = start && ready;
  assign tim_zero  = (tim_q == '0);
  assign gap_load  = TimW'(gap_q) - TimW'(1);
  // Widened compare so count = 2^CNT_W-1 terminates without sent wrapping.
  assign last_pair = ((CNT_W+1)'(sent) + (CNT_W+1)'(1)) == (CNT_W+1)'(count_q);

  // Next-state, timer and pair-counter logic.
  always_comb begin
    state_d = state_q;
    tim_d   = tim_q;
    count_d = count_q;
    gap_d   = gap_q;
    sent_d  = sent;

    unique case (state_q)
      StIdle: ;
      StLead: begin
        if (tim_zero) state_d = StArm;
        else          tim_d   = tim_q - TimW'(1);
      end
      StArm: begin
        if (gap_q == '0) begin
          state_d = StFire;
        end else begin
          state_d = StGapA;
          tim_d   = gap_load;
        end
      end
      StGapA: begin
        if (tim_zero) state_d = StFire;
        else          tim_d   = tim_q - TimW'(1);
      end
      StFire: begin
        sent_d = sent + CNT_W'(1);
        if (last_pair) begin
          state_d = StDone;
        end else if (gap_q == '0) begin
          state_d = StArm;
        end else begin
          state_d = StGapB;
          tim_d   = gap_load;
        end
      end
      StGapB: begin
        if (tim_zero) state_d = StArm;
        else          tim_d   = tim_q - TimW'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // ready is only high in StIdle/StDone, so acceptance and abort never overlap.
    if (accept) begin
      count_d = count;
      gap_d   = gap;
      sent_d  = '0;
      tim_d   = LeadLoad;
      state_d = (count == '0) ? StDone : StLead;
    end

    // Abort overrides the transition; a pair finishing in this FIRE still counts.
    if (abort && busy) begin
      state_d = StIdle;
    end
  end

  // State registers plus outputs decoded from the next state, so every output is a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      tim_q   <= '0;
      count_q <= '0;
      gap_q   <= '0;
      sent    <= '0;
      ser     <= 1'b0;
      mark    <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b1;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      tim_q   <= tim_d;
      count_q <= count_d;
      gap_q   <= gap_d;
      sent    <= sent_d;
      ser     <= (state_d == StArm) || (state_d == StFire);
      mark    <= (state_d == StFire);
      busy    <= (state_d != StIdle) && (state_d != StDone);
      ready   <= (state_d == StIdle) || (state_d == StDone);
      done    <= (state_d == StDone);
    end
  end

endmodule

// File: doc/pair_pulse_tx.md
Name: pair_pulse_tx

Overview:
- Serial stimulus transmitter for the team's pair-detect FSM (the "idle/s0/s1" receiver). That receiver emits one dout pulse for every second '1' on its din line.
- This block takes a request for N output pulses and generates the serial bit stream (ser) that makes such a receiver emit exactly N dout pulses.
- The spacing between '1' bits is programmable, and a lead-in of zeros covers the receiver's post-reset idle cycle.
- The block sits in front of the receiver. Its ser output drives the receiver's din input directly.

Parameters:
- CNT_W, 8, width of the pulse-count request and the sent counter.
- GAP_W, 4, width of the gap field (number of zero cycles between consecutive '1' bits).
- LEAD, 1, number of ser=0 cycles emitted after a request is accepted, before the first '1'. Must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request strobe; accepted only when ready=1.
- count  in  CNT_W  number of receiver pulses to produce; sampled on acceptance.
- gap  in  GAP_W  zero cycles between '1' bits; sampled on acceptance.
- abort  in  1  cancel the transfer in progress.
- ready  out  1  high when a new request can be accepted.
- ser  out  1  serial bit stream, connects to the receiver's din.
- mark  out  1  high in the cycle ser carries the second '1' of a pair, i.e. the bit on which the receiver asserts dout.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse when a transfer completes normally.
- sent  out  CNT_W  number of pairs fully emitted in the current or last transfer.

Behaviour:
- All outputs are registered.
- Reset values (rst=0, asynchronous): state=IDLE, ser=0, mark=0, busy=0, done=0, sent=0, ready=1. Reset mid-transfer aborts immediately; no done pulse.
- States: IDLE, LEAD, ARM, GAP_A, FIRE, GAP_B, DONE.
- Acceptance: start=1 and ready=1 at a rising edge. On acceptance:
  - latch count and gap; clear sent to 0;
  - set busy=1, ready=0.
  - If the latched count=0, go to DONE. Otherwise go to LEAD.
- Timing, with cycle 0 = first cycle after the acceptance edge:
  - LEAD: ser=0 for cycles 0..LEAD-1.
  - ARM: ser=1, mark=0, for one cycle (cycle LEAD).
  - GAP_A: ser=0 for gap cycles. Skipped when gap=0.
  - FIRE: ser=1, mark=1, for one cycle. sent increments at the end of FIRE.
  - After FIRE: if sent+1==count, go to DONE. Else go to GAP_B (ser=0 for gap cycles; skipped if gap=0), then return to ARM.
- Resulting pattern for pair i (0-based):
  - first '1' at cycle LEAD + i·2(gap+1);
  - FIRE at cycle LEAD + gap + 1 + i·2(gap+1);
  - pair period = 2(gap+1) cycles.
- gap=0 gives a continuous run of 2·count '1' bits.
- DONE lasts one cycle: done=1, ready=1, busy=0, ser=0, mark=0. Then go to IDLE with done=0.
- Back-to-back requests: start accepted in the DONE cycle moves directly to LEAD (count≠0) or DONE (count=0). No extra idle cycle.
- start while ready=0 is ignored. count and gap changing during a transfer have no effect.
- abort=1 at an edge while busy=1:
  - next cycle: IDLE, ser=0, mark=0, busy=0, ready=1, done=0;
  - sent holds the number of completed pairs.
  - abort takes precedence over every transition, including FIRE→DONE.
  - abort in IDLE has no effect.
  - abort and start at the same edge while ready=1: start wins; abort applies only when busy=1.
- count=2^CNT_W-1 is legal. sent never wraps within a transfer.
- ser never carries an odd number of '1' bits in a completed transfer. After an abort it may carry an odd number; the receiver is then left in s1, and recovering it is the user's responsibility (reset the receiver).

Test Plan:
- Reset then start, count=3, gap=0, LEAD=1 → ser = 0,1,1,1,1,1,1,0; mark high at cycles 2, 4, 6; done at cycle 7; sent=3. A connected receiver gives exactly 3 dout pulses.
- count=2, gap=2 → ser 1s at cycles 1, 4, 7, 10; mark at 4 and 10; done at cycle 11; receiver dout aligned with mark.
- count=0 → done at cycle 0, no '1' on ser, sent=0, busy never high.
- Back-to-back: second start (count=1, gap=1) asserted in the done cycle of the first transfer → accepted without a gap; lead-in zero, then 1,0,1; done again; sent=1.
- abort during GAP_B of a count=4, gap=1 transfer after 2 pairs → next cycle busy=0, ready=1, done stays 0, sent=2; start held during busy is ignored.
- Assert rst mid-ARM → outputs take reset values asynchronously, before the next clk edge; a later request runs normally.
